cpu_mem_responder: RTL

Memory-side responder for the CPU core's instruction and data channels. It owns a 2^ADDR_WIDTH-word RAM and answers both channels: the instruction request/response pair and the memory request/response pair. It handshakes with programmable latency so the CPU's wait states are exercised, and is used as the memory model in the core testbench and as the on-chip memory in small builds.

---
 rtl/cpu_mem_responder.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU instruction and data channels.
// A single FSM serves one transaction at a time from a word-addressed RAM,
// with programmable request and response latency to exercise CPU wait states.
// Handshake: a request is accepted in the single cycle its Ack pulses;
// a response is held (Valid high, data stable) until the matching Ack is
// sampled high, after which Valid drops on the next cycle.
module cpu_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int REQ_LAT    = 1,
    parameter int RESP_LAT   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] REQ_CNT  = 4'(REQ_LAT);
    localparam logic [3:0] RESP_CNT = 4'(RESP_LAT - 1);
    localparam logic CH_INST = 1'b0;
    localparam logic CH_DATA = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_WAIT,
        S_ACCEPT,
        S_RESP_WAIT,
        S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ch_q, ch_d;
    logic        wr_q, wr_d;
    logic [31:0] resp_q;
    logic [31:0] inst_q;
    logic [31:0] rdata_q;

    logic [31:0] mem [0:DEPTH-1];

    logic                  data_req;
    logic                  sel_valid;
    logic                  sel_ack;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           ram_word;
    logic [31:0]           resp_word;
    logic                  unused_addr_bits;

    // Address bits outside the word index are deliberately ignored (wrap).
    assign unused_addr_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                                Address[31:ADDR_WIDTH+2], Address[1:0]};

    assign data_req  = MemRead | MemWrite;
    assign sel_valid = (ch_q == CH_DATA) ? data_req : Inst_Req_Valid;
    assign sel_ack   = (ch_q == CH_DATA) ? Read_data_Ack : Inst_Ack;
    assign word_idx  = (ch_q == CH_DATA) ? Address[ADDR_WIDTH+1:2] : PC[ADDR_WIDTH+1:2];
    assign ram_word  = mem[word_idx];
    // With RESP_LAT=1 the response is delivered straight from the RAM read.
    assign resp_word = (state_q == S_ACCEPT) ? ram_word : resp_q;

    // Next-state logic: arbitration, latency counting, abort and handshake.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ch_d    = ch_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (data_req || Inst_Req_Valid) begin
                    ch_d = data_req ? CH_DATA : CH_INST;
                    wr_d = data_req & MemWrite;
                    if (REQ_LAT == 0) begin
                        state_d = S_ACCEPT;
                    end else begin
                        state_d = S_REQ_WAIT;
                        cnt_d   = REQ_CNT;
                    end
                end
            end
            S_REQ_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!sel_valid) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (wr_q) begin
                    state_d = S_IDLE;
                end else if (RESP_LAT <= 1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RESP_WAIT;
                    cnt_d   = RESP_CNT;
                end
            end
            S_RESP_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (sel_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM and response registers; outputs clear asynchronously on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ch_q    <= CH_INST;
            wr_q    <= 1'b0;
            resp_q  <= 32'd0;
            inst_q  <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            wr_q    <= wr_d;
            if (state_q == S_ACCEPT && !wr_q) begin
                resp_q <= ram_word;
            end
            if (state_d == S_RESP && state_q != S_RESP) begin
                if (ch_q == CH_INST) begin
                    inst_q <= resp_word;
                end else begin
                    rdata_q <= resp_word;
                end
            end
        end
    end

    // Byte-masked store, committed at the end of the ACCEPT cycle.
    always_ff @(posedge clk) begin
        if (state_q == S_ACCEPT && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (Write_strb[i]) begin
                    mem[word_idx][8*i +: 8] <= Write_data[8*i +: 8];
                end
            end
        end
    end

    assign Inst_Req_Ack    = (state_q == S_ACCEPT) && (ch_q == CH_INST);
    assign Mem_Req_Ack     = (state_q == S_ACCEPT) && (ch_q == CH_DATA);
    assign Inst_Valid      = (state_q == S_RESP)   && (ch_q == CH_INST);
    assign Read_data_Valid = (state_q == S_RESP)   && (ch_q == CH_DATA);
    assign Instruction     = inst_q;
    assign Read_data       = rdata_q;

endmodule
